// File: rtl/match_req_issuer_pkg.sv
// Shared widths, tag layout and small helpers for the match request issuer.
// The `defines mirror parameters.vh and only apply when it was not included first.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 5
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif

package match_req_issuer_pkg;
    localparam int ADDR_W   = `ADDR_WIDTH;
    localparam int PE_W     = `NUM_JOB_PE_LOG2;
    localparam int LEN_W    = `MAX_MATCH_LEN_LOG2 + 1;
    localparam int SEQ_W    = 6;
    localparam int CAND_MAX = 4;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction
endpackage

// File: rtl/match_best_select.sv
// Decides whether an incoming (len, idx) response replaces the current best.
module match_best_select
    import match_req_issuer_pkg::*;
(
    input  logic             best_vld_i,
    input  logic [LEN_W-1:0] best_len_i,
    input  logic [1:0]       best_idx_i,
    input  logic [LEN_W-1:0] in_len_i,
    input  logic [1:0]       in_idx_i,
    output logic             take_o
);
    // Responses arrive out of order, so ties are resolved by index, not arrival.
    assign take_o = !best_vld_i || (in_len_i > best_len_i) ||
                    ((in_len_i == best_len_i) && (in_idx_i < best_idx_i));
endmodule

// File: rtl/match_req_issuer.sv
// Issues one match request per masked history candidate, collects responses
// in any order and reports the longest match for a single in-flight job.
module match_req_issuer
    import match_req_issuer_pkg::*;
#(
    parameter int JOB_PE_ID = 0,
    parameter int NUM_CAND  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_job_valid,
    output logic                       o_job_ready,
    input  logic [ADDR_W-1:0]          i_job_head_addr,
    input  logic [NUM_CAND*ADDR_W-1:0] i_job_history_addr,
    input  logic [NUM_CAND-1:0]        i_job_cand_mask,
    output logic                       o_match_req_valid,
    input  logic                       i_match_req_ready,
    output logic [PE_W-1:0]            o_match_req_job_pe_id,
    output logic [7:0]                 o_match_req_tag,
    output logic [ADDR_W-1:0]          o_match_req_head_addr,
    output logic [ADDR_W-1:0]          o_match_req_history_addr,
    input  logic                       i_match_resp_valid,
    output logic                       o_match_resp_ready,
    input  logic [PE_W-1:0]            i_match_resp_job_pe_id,
    input  logic [7:0]                 i_match_resp_tag,
    input  logic [LEN_W-1:0]           i_match_resp_match_len,
    output logic                       o_result_valid,
    input  logic                       i_result_ready,
    output logic [ADDR_W-1:0]          o_result_head_addr,
    output logic [ADDR_W-1:0]          o_result_history_addr,
    output logic [1:0]                 o_result_cand_idx,
    output logic [LEN_W-1:0]           o_result_match_len
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             init_q;
    logic [SEQ_W-1:0] seq_q;
    logic [ADDR_W-1:0] head_q;
    logic [ADDR_W-1:0] hist_q [CAND_MAX];
    logic [3:0]       mask_q, issued_q, issued_d, rcvd_q, rcvd_d;
    logic             best_vld_q;
    logic [LEN_W-1:0] best_len_q;
    logic [1:0]       best_idx_q;

    logic [ADDR_W-1:0] job_hist [CAND_MAX];
    logic [3:0]       job_mask4;
    logic [1:0]       cur_idx, resp_idx;
    logic             job_fire, req_fire, resp_ok, take;

    for (genvar k = 0; k < CAND_MAX; k++) begin : g_unpack
        if (k < NUM_CAND) begin : g_on
            assign job_hist[k] = i_job_history_addr[k*ADDR_W +: ADDR_W];
        end else begin : g_off
            assign job_hist[k] = '0;
        end
    end
    assign job_mask4 = 4'(i_job_cand_mask);

    assign job_fire = o_job_ready & i_job_valid;
    assign req_fire = o_match_req_valid & i_match_req_ready;
    assign cur_idx  = first_set(mask_q & ~issued_q);
    assign issued_d = req_fire ? (issued_q | onehot(cur_idx)) : issued_q;

    // Only responses for this job, issued and not yet seen, may touch state.
    assign resp_idx = i_match_resp_tag[1:0];
    assign resp_ok  = i_match_resp_valid && ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                      (i_match_resp_job_pe_id == PE_W'(JOB_PE_ID)) &&
                      (i_match_resp_tag[7:2] == seq_q) &&
                      issued_q[resp_idx] && !rcvd_q[resp_idx];
    assign rcvd_d   = resp_ok ? (rcvd_q | onehot(resp_idx)) : rcvd_q;

    match_best_select u_best (
        .best_vld_i (best_vld_q),
        .best_len_i (best_len_q),
        .best_idx_i (best_idx_q),
        .in_len_i   (i_match_resp_match_len),
        .in_idx_i   (resp_idx),
        .take_o     (take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // An empty mask still passes through the completion check in WAIT.
            S_IDLE:   if (job_fire) state_d = (job_mask4 == 4'b0) ? S_WAIT : S_ISSUE;
            S_ISSUE:  if ((mask_q & ~issued_d) == 4'b0) state_d = S_WAIT;
            S_WAIT:   if (rcvd_d == mask_q) state_d = S_OUTPUT;
            S_OUTPUT: if (i_result_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_job_ready       = 1'b0;
        o_match_req_valid = 1'b0;
        o_result_valid    = 1'b0;
        case (state_q)
            S_IDLE:   o_job_ready       = init_q;
            S_ISSUE:  o_match_req_valid = 1'b1;
            S_OUTPUT: o_result_valid    = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            seq_q      <= '0;
            head_q     <= '0;
            for (int k = 0; k < CAND_MAX; k++) hist_q[k] <= '0;
            mask_q     <= '0;
            issued_q   <= '0;
            rcvd_q     <= '0;
            best_vld_q <= 1'b0;
            best_len_q <= '0;
            best_idx_q <= '0;
        end else begin
            init_q <= 1'b1;
            if (job_fire) begin
                head_q     <= i_job_head_addr;
                for (int k = 0; k < CAND_MAX; k++) hist_q[k] <= job_hist[k];
                mask_q     <= job_mask4;
                issued_q   <= '0;
                rcvd_q     <= '0;
                best_vld_q <= 1'b0;
                best_len_q <= '0;
                best_idx_q <= '0;
            end else begin
                issued_q <= issued_d;
                rcvd_q   <= rcvd_d;
                if (resp_ok && take) begin
                    best_vld_q <= 1'b1;
                    best_len_q <= i_match_resp_match_len;
                    best_idx_q <= resp_idx;
                end
            end
            if (o_result_valid && i_result_ready) seq_q <= seq_q + 1'b1;
        end
    end

    assign o_match_resp_ready       = 1'b1;
    assign o_match_req_job_pe_id    = PE_W'(JOB_PE_ID);
    assign o_match_req_tag          = {seq_q, cur_idx};
    assign o_match_req_head_addr    = head_q;
    assign o_match_req_history_addr = hist_q[cur_idx];
    assign o_result_head_addr       = head_q;
    assign o_result_history_addr    = best_vld_q ? hist_q[best_idx_q] : '0;
    assign o_result_cand_idx        = best_idx_q;
    assign o_result_match_len       = best_len_q;
endmodule
